// File: rtl/btn_debounce_counter.sv
// Push-button conditioner: 2-FF sync, debounce FSM, press/release pulses,
// 16-bit press counter. Optional auto-repeat with BTN_AUTOREPEAT_EN.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   btn_in       in   raw button, asynchronous, may bounce
//   btn_level    out  debounced button level
//   btn_press    out  one-cycle pulse per accepted press / auto-repeat
//   btn_release  out  one-cycle pulse per accepted release
//   press_count  out  16-bit count of btn_press pulses, wraps silently
//
// Build macro: BTN_AUTOREPEAT_EN enables auto-repeat while held.

module btn_debounce_counter #(
  parameter int unsigned C_DEBOUNCE_COUNT = 1_000_000,
  parameter int unsigned C_REPEAT_DELAY   = 50_000_000,
  parameter int unsigned C_REPEAT_PERIOD  = 10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_in,
  output logic        btn_level,
  output logic        btn_press,
  output logic        btn_release,
  output logic [15:0] press_count
);

  localparam int CW = $clog2(C_DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_DEBOUNCE_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_e;

  logic          sync1_q, sync2_q;
  logic          btn_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [15:0]   count_q, count_d;

  assign btn_s = sync2_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RMAX =
    (C_REPEAT_DELAY > C_REPEAT_PERIOD) ? C_REPEAT_DELAY : C_REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(C_REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(C_REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_q, rpt_d;
  // Set once the initial delay has elapsed; later repeats use the period.
  logic          rpt_first_q, rpt_first_d;
  logic          stay_held;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(C_REPEAT_DELAY), 32'(C_REPEAT_PERIOD)};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          count_d = count_q + 16'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef BTN_AUTOREPEAT_EN
    // Counter only runs while staying in HELD; any other cycle clears it,
    // so a bounce back into HELD restarts the initial delay.
    stay_held   = (state_q == HELD) && btn_s;
    rpt_d       = '0;
    rpt_first_d = 1'b0;
    if (stay_held) begin
      rpt_first_d = rpt_first_q;
      if (rpt_q == (rpt_first_q ? PER_LAST : DLY_LAST)) begin
        rpt_d       = '0;
        rpt_first_d = 1'b1;
        press_d     = 1'b1;
        count_d     = count_q + 16'd1;
      end else begin
        rpt_d = rpt_q + RW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign press_count = count_q;

endmodule
